// File: rtl/systolic_pkg.sv
// Shared types and timing helpers for the systolic array operand feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    // Cycles from accept to the DONE cycle
    function automatic int done_lat(input int n, input int lat);
        return 3 * n - 2 + lat;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Enabled delay line with synchronous clear; DEPTH=0 collapses to a wire.
module skew_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{i_clk, i_rst, i_en};
        assign o_q = i_d;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe_q [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int s = 0; s < DEPTH; s++) pipe_q[s] <= '0;
            end else if (i_en) begin
                pipe_q[0] <= i_d;
                for (int s = 1; s < DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
            end
        end

        assign o_q = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Captures two NxN matrices and streams them as skewed row/column lanes
// into an output-stationary systolic array, flagging completion.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int W   = 16,
    parameter int N   = 3,
    parameter int LAT = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic           i_start,
    input  logic           i_mode,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    output logic [W*N-1:0] o_A,
    output logic [W*N-1:0] o_B,
    output logic           o_mode,
    output logic           o_ready,
    output logic           o_busy,
    output logic           o_done
);

    localparam int CW = $clog2(3 * N + LAT + 1);
    localparam int DLAT = done_lat(N, LAT);
    localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DLAT - 2);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [W*N*N-1:0] a_q;
    logic [W*N*N-1:0] b_q;
    logic             mode_q;
    logic [W*N-1:0]   raw_a_d;
    logic [W*N-1:0]   raw_b_d;

    // Counter value in cycle t0+m is m-1, so it doubles as the FEED step k
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else if (i_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_FEED;
                        cnt_q   <= '0;
                        a_q     <= i_A;
                        b_q     <= i_B;
                        mode_q  <= i_mode;
                    end
                end
                S_FEED: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == FEED_LAST) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == DRAIN_LAST) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        raw_a_d = '0;
        raw_b_d = '0;
        if (state_q == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                raw_a_d[i*W +: W] = a_q[(i*N + int'(cnt_q))*W +: W];
                raw_b_d[i*W +: W] = b_q[(int'(cnt_q)*N + i)*W +: W];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.WIDTH(W), .DEPTH(i)) u_skew_a (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (i_en),
            .i_d   (raw_a_d[i*W +: W]),
            .o_q   (o_A[i*W +: W])
        );
        skew_line #(.WIDTH(W), .DEPTH(i)) u_skew_b (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (i_en),
            .i_d   (raw_b_d[i*W +: W]),
            .o_q   (o_B[i*W +: W])
        );
    end

    assign o_mode  = mode_q;
    assign o_ready = (state_q == S_IDLE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: N=3/LAT=1 and N=4/LAT=2 instances against a lane-formula model.
module tb_systolic_feeder;

    logic clk = 1'b0;
    logic rst, en, start, mode;
    logic [143:0] a0, b0;
    logic [255:0] a1, b1;
    logic [47:0]  oa0, ob0;
    logic [63:0]  oa1, ob1;
    logic omode0, rdy0, busy0, done0;
    logic omode1, rdy1, busy1, done1;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    systolic_feeder #(.W(16), .N(3), .LAT(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start),
        .i_mode(mode), .i_A(a0), .i_B(b0), .o_A(oa0), .o_B(ob0),
        .o_mode(omode0), .o_ready(rdy0), .o_busy(busy0), .o_done(done0)
    );

    systolic_feeder #(.W(16), .N(4), .LAT(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start),
        .i_mode(mode), .i_A(a1), .i_B(b1), .o_A(oa1), .o_B(ob1),
        .o_mode(omode1), .o_ready(rdy1), .o_busy(busy1), .o_done(done1)
    );

    // Model: s = enabled edges since accept; lane i shows element k=s-1-i
    int capA [2][16];
    int capB [2][16];
    bit mbusy [2];
    bit mmode [2];
    int ms [2];

    function automatic int nn(input int d);
        return d ? 4 : 3;
    endfunction

    function automatic int dl(input int d);
        return 3 * nn(d) - 2 + (d ? 2 : 1);
    endfunction

    function automatic int exp_a(input int d, input int i);
        int k;
        k = ms[d] - 1 - i;
        if (!mbusy[d] || k < 0 || k >= nn(d)) return 0;
        return capA[d][i*nn(d) + k];
    endfunction

    function automatic int exp_b(input int d, input int j);
        int k;
        k = ms[d] - 1 - j;
        if (!mbusy[d] || k < 0 || k >= nn(d)) return 0;
        return capB[d][k*nn(d) + j];
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mbusy[d] = 1'b0;
                mmode[d] = 1'b0;
                ms[d] = 0;
            end else if (en) begin
                if (!mbusy[d]) begin
                    if (start) begin
                        mbusy[d] = 1'b1;
                        ms[d] = 1;
                        mmode[d] = mode;
                        for (int e = 0; e < nn(d)*nn(d); e++) begin
                            capA[d][e] = d ? int'(a1[e*16 +: 16]) : int'(a0[e*16 +: 16]);
                            capB[d][e] = d ? int'(b1[e*16 +: 16]) : int'(b0[e*16 +: 16]);
                        end
                    end
                end else if (ms[d] == dl(d)) begin
                    mbusy[d] = 1'b0;
                end else begin
                    ms[d] = ms[d] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m0_ready", int'(rdy0), int'(!mbusy[0]));
            chk("m0_busy", int'(busy0), int'(mbusy[0]));
            chk("m0_done", int'(done0), int'(mbusy[0] && ms[0] == dl(0)));
            chk("m0_mode", int'(omode0), int'(mmode[0]));
            chk("m1_ready", int'(rdy1), int'(!mbusy[1]));
            chk("m1_busy", int'(busy1), int'(mbusy[1]));
            chk("m1_done", int'(done1), int'(mbusy[1] && ms[1] == dl(1)));
            chk("m1_mode", int'(omode1), int'(mmode[1]));
            for (int i = 0; i < 3; i++) begin
                chk("m0_oA", int'(oa0[i*16 +: 16]), exp_a(0, i));
                chk("m0_oB", int'(ob0[i*16 +: 16]), exp_b(0, i));
            end
            for (int i = 0; i < 4; i++) begin
                chk("m1_oA", int'(oa1[i*16 +: 16]), exp_a(1, i));
                chk("m1_oB", int'(ob1[i*16 +: 16]), exp_b(1, i));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_known();
        for (int e = 0; e < 9; e++) begin
            a0[e*16 +: 16] = 16'(e + 1);
            b0[e*16 +: 16] = (e % 4 == 0) ? 16'd1 : 16'd0;
        end
        for (int e = 0; e < 16; e++) begin
            a1[e*16 +: 16] = 16'(e + 1);
            b1[e*16 +: 16] = 16'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; mode = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step();
        chk_on = 1'b1;
        chk("rst_ready", int'(rdy0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_oA", int'(oa0 != 0), 0);
        chk("rst_oB", int'(ob0 != 0), 0);
        rst = 1'b0;
        load_known();
        idle(2);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            chk("t1_a_l0", int'(oa0[15:0]), (m <= 3) ? m : 0);
            chk("t1_a_l2", int'(oa0[47:32]), (m >= 3 && m <= 5) ? m + 4 : 0);
            chk("t1_b_l1", int'(ob0[31:16]), (m == 3) ? 1 : 0);
            chk("t1_done", int'(done0), (m == 8) ? 1 : 0);
            step();
        end
        idle(20);

        start = 1'b1;
        step();
        for (int m = 1; m <= 11; m++) begin
            if (m <= 8) chk("t2_busy", int'(busy0), 1);
            if (m == 9) chk("t2_ready", int'(rdy0), 1);
            if (m == 10) begin
                chk("t2_rebusy", int'(busy0), 1);
                chk("t2_relane", int'(oa0[15:0]), 1);
            end
            step();
        end
        idle(30);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            en = !(m == 2 || m == 3);
            chk("t3_a_l0", int'(oa0[15:0]),
                (m <= 2) ? m : (m <= 4) ? 2 : (m == 5) ? 3 : 0);
            chk("t3_done", int'(done0), (m == 10) ? 1 : 0);
            step();
        end
        en = 1'b1;
        idle(20);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int m = 1; m <= 3; m++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int m = 5; m <= 24; m++) begin
            chk("t4_busy", int'(busy0), 0);
            chk("t4_lanes", int'(oa0 != 0 || ob0 != 0), 0);
            chk("t4_done", int'(done0), 0);
            step();
        end

        load_known();
        mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = 1'b0;
        a1 = {8{$urandom}};
        for (int m = 1; m <= 14; m++) begin
            chk("t5_mode", int'(omode1), 1);
            chk("t5_done", int'(done1), (m == 12) ? 1 : 0);
            chk("t5_a_l3", int'(oa1[63:48]), (m >= 4 && m <= 7) ? m + 9 : 0);
            step();
        end
        idle(10);

        for (int c = 0; c < 500; c++) begin
            rst = ($urandom % 60) == 0;
            en = ($urandom % 5) != 0;
            start = ($urandom % 3) == 0;
            mode = 1'($urandom);
            for (int e = 0; e < 9; e++) begin
                a0[e*16 +: 16] = 16'($urandom);
                b0[e*16 +: 16] = 16'($urandom);
            end
            for (int e = 0; e < 16; e++) begin
                a1[e*16 +: 16] = 16'($urandom);
                b1[e*16 +: 16] = 16'($urandom);
            end
            step();
        end
        rst = 1'b0;
        en = 1'b1;
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter W, default 16: element width in bits.
REQ-002 Parameter N, default 3: array dimension; N x N matrices, N lanes per side; legal range 2..16.
REQ-003 Parameter LAT, default 1: array accumulate latency in cycles, counted from the last operand reaching PE(N-1,N-1) to its result being valid.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_en  in  1  global enable; 0 = freeze.
REQ-007 i_start  in  1  request to start a multiply; accepted only when o_ready=1.
REQ-008 i_mode  in  1  0 = clear-and-compute, 1 = accumulate onto existing results.
REQ-009 i_A  in  W*N*N  matrix A; element (r,c) occupies bits [(r*N+c)*W +: W].
REQ-010 i_B  in  W*N*N  matrix B; same packing as i_A.
REQ-011 o_A  out  W*N  skewed row-side lanes to the array; lane i occupies bits [i*W +: W].
REQ-012 o_B  out  W*N  skewed column-side lanes; same packing as o_A.
REQ-013 o_mode  out  1  latched i_mode, stable while o_busy=1.
REQ-014 o_ready  out  1  high in IDLE.
REQ-015 o_busy  out  1  high in any state other than IDLE.
REQ-016 o_done  out  1  high in the DONE state.

Function
REQ-017 FSM states are IDLE, FEED, DRAIN and DONE; one shared cycle counter advances only when i_en=1.
REQ-018 Accept cycle t0 is the enabled cycle with i_start=1 in IDLE: i_A, i_B and i_mode are captured; the FSM moves to FEED with k=0.
REQ-019 FEED lasts N enabled cycles, k=0..N-1, then moves to DRAIN.
REQ-020 Raw lane i of A during FEED step k is A(i,k); raw lane j of B is B(k,j); all raw lanes are 0 outside FEED.
REQ-021 Output lane i is raw lane i delayed by i enabled cycles; lane 0 is combinational from the registered state and captured data.
REQ-022 DRAIN ends so that o_done is high exactly in cycle t0+3N-2+LAT when i_en stays 1; for N=3 and LAT=1 this is t0+8.
REQ-023 DONE lasts one enabled cycle, then the FSM returns to IDLE; a new accept is possible in the following cycle.
REQ-024 i_start is ignored while o_busy=1; changes on i_A, i_B and i_mode after t0 have no effect.
REQ-025 When i_en=0, the FSM, the counter and all skew registers hold; o_A, o_B and o_done hold their values.
REQ-026 Counter width is $clog2(3N+LAT+1); no wrap-around is reachable.
REQ-027 o_mode updates only at the accept edge.

Reset
REQ-028 An asserted i_rst at a clock edge forces IDLE, clears the counter and all skew registers, and zeros o_A, o_B and o_mode; o_done=0, o_busy=0 and o_ready=1 follow from the state in the next cycle.
REQ-029 i_rst has priority over i_en and i_start and aborts any operation in progress; no o_done is produced for the aborted operation.

Structure
REQ-030 Package systolic_pkg holds the FSM state enum and the latency helper constant for 3N-2+LAT.
REQ-031 Sub-module skew_line(WIDTH, DEPTH) provides the per-lane delay: a register chain with enable and synchronous reset, where DEPTH=0 is a wire; it is instantiated 2N times.

Verification
REQ-032 Reset with i_en=1 -> o_ready=1, o_busy=0, o_done=0, o_A=0, o_B=0.
REQ-033 N=3, A=1..9 row-major, B=identity, start at t0 -> o_A lane0 = 1,2,3 at t0+1..3; lane2 = 7,8,9 at t0+3..5; o_B lane1 = 0,1,0 at t0+2..4; o_done only at t0+8.
REQ-034 i_start held high throughout -> a single accept while busy; the next accept occurs at t0+9.
REQ-035 i_en=0 during t0+2..t0+3 -> outputs frozen for those two cycles; o_done at t0+10.
REQ-036 i_rst pulsed at t0+4 -> o_busy=0 and all lanes 0 from t0+5; no o_done within 20 cycles.
REQ-037 N=4, LAT=2, i_mode=1 -> o_mode=1 from t0+1; o_done at t0+12; o_A lane3 nonzero only during t0+4..t0+7.
